// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel LED PWM controller with per-channel static, blink and breathe effects.
// A shared prescaler generates the effect tick; all outputs are registered.
module rgb_pwm_ctrl #(
    parameter int NCH   = 3,
    parameter int PW    = 8,
    parameter int DIV_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [3:0]     wr_addr,
    input  logic [15:0]    wr_data,
    output logic [NCH-1:0] pwm_o,
    output logic           led_en,
    output logic           tick_o
);

    typedef enum logic {UP, DOWN} br_st_e;

    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_STATIC  = 2'd1;
    localparam logic [1:0] M_BLINK   = 2'd2;
    localparam logic [1:0] M_BREATHE = 2'd3;

    logic [PW-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             tick_q, tick_d;
    logic [NCH-1:0]   pwm_q, pwm_d;
    logic [NCH-1:0]   phase_q, phase_d;
    logic [PW-1:0]    duty_q [NCH];
    logic [PW-1:0]    duty_d [NCH];
    logic [1:0]       mode_q [NCH];
    logic [1:0]       mode_d [NCH];
    logic [PW-1:0]    ramp_q [NCH];
    logic [PW-1:0]    ramp_d [NCH];
    br_st_e           st_q   [NCH];
    br_st_e           st_d   [NCH];
    logic [PW-1:0]    lvl    [NCH];
    logic             tick;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        div_d   = div_q;
        en_d    = en_q;
        phase_d = phase_q;
        pwm_d   = '0;
        tick    = (pcnt_q == div_q);
        tick_d  = tick;
        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;

        if (wr_en && wr_addr == 4'd0) begin
            div_d  = wr_data[DIV_W-1:0];
            pcnt_d = '0;
        end
        if (wr_en && wr_addr == 4'd1) en_d = wr_data[0];

        for (int unsigned k = 0; k < NCH; k++) begin
            duty_d[k] = duty_q[k];
            mode_d[k] = mode_q[k];
            ramp_d[k] = ramp_q[k];
            st_d[k]   = st_q[k];

            case (mode_q[k])
                M_OFF:     lvl[k] = '0;
                M_STATIC:  lvl[k] = duty_q[k];
                M_BLINK:   lvl[k] = phase_q[k] ? duty_q[k] : '0;
                M_BREATHE: lvl[k] = ramp_q[k];
                default:   lvl[k] = '0;
            endcase
            pwm_d[k] = en_q && ((lvl[k] == '1) || (cnt_q < lvl[k]));

            // Effects advance in every mode; selecting a mode restarts them from a clean state.
            if (tick) begin
                phase_d[k] = ~phase_q[k];
                if (st_q[k] == UP) begin
                    if (ramp_q[k] < duty_q[k]) begin
                        ramp_d[k] = ramp_q[k] + 1'b1;
                    end else begin
                        ramp_d[k] = duty_q[k];
                        st_d[k]   = DOWN;
                    end
                end else begin
                    if (ramp_q[k] != '0) ramp_d[k] = ramp_q[k] - 1'b1;
                    else                 st_d[k]   = UP;
                end
            end

            if (wr_en && wr_addr == 4'(2 + 2 * k)) duty_d[k] = wr_data[PW-1:0];
            if (wr_en && wr_addr == 4'(3 + 2 * k)) begin
                mode_d[k]  = wr_data[1:0];
                ramp_d[k]  = '0;
                phase_d[k] = 1'b0;
                st_d[k]    = UP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pcnt_q  <= '0;
            div_q   <= '0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            phase_q <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                duty_q[k] <= '0;
                mode_q[k] <= '0;
                ramp_q[k] <= '0;
                st_q[k]   <= UP;
            end
        end else begin
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            div_q   <= div_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            phase_q <= phase_d;
            for (int unsigned k = 0; k < NCH; k++) begin
                duty_q[k] <= duty_d[k];
                mode_q[k] <= mode_d[k];
                ramp_q[k] <= ramp_d[k];
                st_q[k]   <= st_d[k];
            end
        end
    end

    assign pwm_o  = pwm_q;
    assign led_en = en_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Scoreboard bench for rgb_pwm_ctrl: a cycle model pushes expected outputs each rising edge,
// which are popped and compared on the following falling edge, plus directed counts.
module tb_rgb_pwm_ctrl;

    localparam int NCH   = 3;
    localparam int PW    = 8;
    localparam int DIV_W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [3:0]     wr_addr;
    logic [15:0]    wr_data;
    logic [NCH-1:0] pwm_o;
    logic           led_en;
    logic           tick_o;

    rgb_pwm_ctrl #(.NCH(NCH), .PW(PW), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .pwm_o   (pwm_o),
        .led_en  (led_en),
        .tick_o  (tick_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic           led;
        logic           tick;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int m_cnt, m_pcnt, m_div, m_en;
    int m_duty [NCH];
    int m_mode [NCH];
    int m_ramp [NCH];
    int m_up   [NCH];
    int m_ph   [NCH];

    always @(posedge clk) begin
        exp_t e;
        int   lvl;
        int   tk;
        int   old_duty [NCH];
        if (rst) begin
            m_cnt = 0; m_pcnt = 0; m_div = 0; m_en = 0;
            for (int k = 0; k < NCH; k++) begin
                m_duty[k] = 0; m_mode[k] = 0; m_ramp[k] = 0; m_up[k] = 1; m_ph[k] = 0;
            end
            e = '0;
        end else begin
            tk     = (m_pcnt == m_div);
            e.tick = tk[0];
            e.pwm  = '0;
            for (int k = 0; k < NCH; k++) begin
                case (m_mode[k])
                    1:       lvl = m_duty[k];
                    2:       lvl = m_ph[k] ? m_duty[k] : 0;
                    3:       lvl = m_ramp[k];
                    default: lvl = 0;
                endcase
                e.pwm[k]    = (m_en != 0) && (lvl == 255 || m_cnt < lvl);
                old_duty[k] = m_duty[k];
            end
            if (wr_en && wr_addr == 1) m_en = wr_data[0];
            e.led = m_en[0];

            m_cnt = (m_cnt + 1) % 256;
            if (wr_en && wr_addr == 0) begin
                m_div  = wr_data;
                m_pcnt = 0;
            end else begin
                m_pcnt = tk ? 0 : m_pcnt + 1;
            end
            for (int k = 0; k < NCH; k++) begin
                if (wr_en && wr_addr == 3 + 2 * k) begin
                    m_mode[k] = wr_data[1:0];
                    m_ramp[k] = 0; m_ph[k] = 0; m_up[k] = 1;
                end else if (tk) begin
                    m_ph[k] = 1 - m_ph[k];
                    if (m_up[k]) begin
                        if (m_ramp[k] < old_duty[k]) m_ramp[k]++;
                        else begin m_ramp[k] = old_duty[k]; m_up[k] = 0; end
                    end else begin
                        if (m_ramp[k] > 0) m_ramp[k]--;
                        else m_up[k] = 1;
                    end
                end
                if (wr_en && wr_addr == 2 + 2 * k) m_duty[k] = wr_data[PW-1:0];
            end
        end
        exp_q.push_back(e);
    end

    // Scoreboard compare; the per-cycle counts are aggregated so the log stays short
    int sb_cnt  = 0;
    int sb_bad  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sb_cnt++;
            if ({pwm_o, led_en, tick_o} !== e) begin
                sb_bad++;
                if (sb_bad <= 10) chk($sformatf("sb_cyc%0d", sb_cnt), {pwm_o, led_en, tick_o}, e);
                else n_chk++;
            end else begin
                chk("sb", {pwm_o, led_en, tick_o}, e);
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic count_bit(input int idx, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            hi += pwm_o[idx];
        end
    endtask

    initial begin
        int hi, hi1, hi2, gap, seen, ticks;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_o, 0);
        chk("rst_led", led_en, 0);
        chk("rst_tick", tick_o, 0);
        // reset wins over a simultaneous write
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h1;
        @(negedge clk);
        chk("rst_over_wr", led_en, 0);
        rst = 1'b0; wr_en = 1'b0;

        // static 25%
        wr(4'd1, 16'h1);
        chk("led_on", led_en, 1);
        wr(4'd2, 16'h40);
        wr(4'd3, 16'h1);
        repeat (4) @(negedge clk);
        count_bit(0, 256, hi);
        chk("static_64", hi, 64);
        count_bit(0, 256, hi);
        chk("static_64_again", hi, 64);
        count_bit(1, 128, hi1);
        count_bit(2, 128, hi2);
        chk("others_off", hi1 + hi2, 0);

        // extremes
        wr(4'd4, 16'hFF);
        wr(4'd5, 16'h1);
        @(negedge clk);
        count_bit(1, 300, hi);
        chk("duty_ff_high", hi, 300);
        wr(4'd4, 16'h00);
        @(negedge clk);
        count_bit(1, 300, hi);
        chk("duty_00_low", hi, 0);

        // breathe with div=0, then restart mid-ramp
        wr(4'd6, 16'h4);
        wr(4'd7, 16'h3);
        repeat (40) @(negedge clk);
        wr(4'd7, 16'h3);
        repeat (7) @(negedge clk);
        wr(4'd6, 16'h2);
        repeat (30) @(negedge clk);

        // blink with div=9
        wr(4'd0, 16'd9);
        wr(4'd2, 16'h80);
        wr(4'd3, 16'h2);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (tick_o) seen = 1;
        end
        chk("tick_seen", seen, 1);
        gap = 0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (tick_o) seen = 1;
        end
        chk("tick_period", gap, 10);
        repeat (80) @(negedge clk);

        // global off keeps ticking
        wr(4'd1, 16'h0);
        chk("led_off", led_en, 0);
        @(negedge clk);
        chk("pwm_off", pwm_o, 0);
        ticks = 0;
        repeat (20) begin
            @(negedge clk);
            ticks += tick_o;
        end
        chk("ticks_while_off", ticks, 2);

        // reset mid-breathe
        wr(4'd1, 16'h1);
        wr(4'd0, 16'd0);
        wr(4'd2, 16'h30);
        wr(4'd3, 16'h3);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_out", {pwm_o, led_en, tick_o}, 0);
        wr(4'd1, 16'h1);
        wr(4'd3, 16'h1);
        count_bit(0, 64, hi);
        chk("no_duty_after_rst", hi, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
